// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/response bundle between the control unit and
// the multi-cycle shift sequencer.
//
//   start        control -> seq   request, sampled only while idle
//   op           control -> seq   00 sll, 01 srl, 10 sra, 11 treated as sll
//   input_a      control -> seq   operand (rt value)
//   shamt        control -> seq   shift amount 0..31
//   busy         seq -> control   high while shifting and in the done cycle
//   done         seq -> control   one-cycle pulse, shift_result valid
//   shift_result seq -> control   result register, held until next accept
//   stage_s      seq -> control   1-bit stage select, high on shifting cycles
//
// Modports: master = control unit side, slave = sequencer side.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] input_a;
    logic [4:0]       shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] shift_result;
    logic             stage_s;

    modport master (
        output start, op, input_a, shamt,
        input  busy, done, shift_result, stage_s
    );

    modport slave (
        input  start, op, input_a, shamt,
        output busy, done, shift_result, stage_s
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: executes sll/srl (and sra when enabled) by applying a
// single 1-bit shift stage to the result register once per clock.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    shift_sequencer_if.slave (start/op/input_a/shamt in,
//          busy/done/shift_result/stage_s out)
//
// Configuration macro: SHIFT_SEQ_SRA_EN
//   defined   -> op 10 is an arithmetic right shift (sign fill)
//   undefined -> op 10 behaves as srl (zero fill), no sign-fill logic built
//
// Latency: shamt N >= 1 gives done N+1 cycles after accept; shamt 0 gives 1.
module shift_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stage_s_q, stage_s_d;

    logic [WIDTH-1:0] shifted;

    // One-bit shift stage; op 11 falls through to sll.
    always_comb begin
        shifted = {result_q[WIDTH-2:0], 1'b0};
        case (op_q)
            2'b01: shifted = {1'b0, result_q[WIDTH-1:1]};
`ifdef SHIFT_SEQ_SRA_EN
            2'b10: shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`else
            2'b10: shifted = {1'b0, result_q[WIDTH-1:1]};
`endif
            default: shifted = {result_q[WIDTH-2:0], 1'b0};
        endcase
    end

    // Outputs are registered: their next values are decided alongside the
    // state transition so they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        stage_s_d = 1'b0;

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    op_d     = bus.op;
                    result_d = bus.input_a;
                    count_d  = bus.shamt;
                    busy_d   = 1'b1;
                    if (bus.shamt == 5'd0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = StShift;
                        stage_s_d = 1'b1;
                    end
                end
            end
            StShift: begin
                result_d = shifted;
                count_d  = count_q - 5'd1;
                // Entered only with count >= 1, so this never wraps.
                if (count_q == 5'd1) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    stage_s_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            result_q  <= '0;
            count_q   <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stage_s_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            result_q  <= result_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stage_s_q <= stage_s_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.shift_result = result_q;
    assign bus.stage_s      = stage_s_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed-vector bench for shift_sequencer. Inputs are
// driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_shift_sequencer;

    logic clk;
    logic rst_n;

    shift_sequencer_if #(.WIDTH(32)) bus ();

    shift_sequencer #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, then wait (bounded)
    // for done and check latency, stage_s count, result and the idle cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [4:0] sh, input logic [31:0] exp_res);
        int lat;
        int stg;
        logic [31:0] held;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.input_a = a;
        bus.shamt   = sh;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op      = 2'b01;
        bus.input_a = 32'h5A5A_5A5A;
        bus.shamt   = 5'd17;
        lat = 1;
        stg = 0;
        while (!bus.done && lat < 40) begin
            if (bus.stage_s) stg++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(sh) + 32'd1);
        check({tag, "_stage_cycles"}, 32'(stg), 32'(sh));
        check({tag, "_result"}, bus.shift_result, exp_res);
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
        check({tag, "_stage_in_done"}, 32'(bus.stage_s), 32'd0);
        held = bus.shift_result;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_result_held"}, bus.shift_result, held);
    endtask

    initial begin
        int dn;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.input_a = 32'h0;
        bus.shamt   = 5'd0;
        rst_n       = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_stage", 32'(bus.stage_s), 32'd0);
        check("rst_result", bus.shift_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
        end

        // Main function
        run_op("sll_31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_op("srl_4", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000);
`ifdef SHIFT_SEQ_SRA_EN
        run_op("sra_4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
`else
        run_op("sra_4", 2'b10, 32'h8000_0000, 5'd4, 32'h0800_0000);
`endif
        run_op("zero", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        run_op("srl_8", 2'b01, 32'hF0F0_0000, 5'd8, 32'h00F0_F000);
        run_op("srl_1", 2'b01, 32'h8000_0001, 5'd1, 32'h4000_0000);
        run_op("op11_3", 2'b11, 32'h0000_0001, 5'd3, 32'h0000_0008);
        run_op("sll_31_lsb", 2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);

        // Busy ignore: start pulse mid-operation must not restart or queue
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.input_a = 32'h3; bus.shamt = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.input_a = 32'hFFFF_FFFF; bus.shamt = 5'd1;
        @(negedge clk);
        bus.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dn++;
                check("ignore_result", bus.shift_result, 32'h0000_0060);
            end
        end
        check("ignore_done_count", 32'(dn), 32'd1);

        // Abort: reset mid-operation clears outputs at once, no done
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.input_a = 32'h1; bus.shamt = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_stage", 32'(bus.stage_s), 32'd0);
        check("abort_result", bus.shift_result, 32'h0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        run_op("post_abort", 2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
